fetch_unit: RTL and testbench

- Instruction fetch and PC sequencing stage directly upstream of control_unit in the non-pipelined core.
- Holds the PC and issues valid/ready requests to instruction memory.
- Latches the returned instruction and presents opcode/funct3/funct7_5 fields to the control unit.
- Consumes pc_src plus the extended branch immediate to select the next PC at the end of each executed instruction.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_next_pc_sel.sv | 20 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OPC_W        = 7;
  localparam int unsigned F3_W         = 3;
  localparam int unsigned OPC_LSB      = 0;
  localparam int unsigned F3_LSB       = 12;
  localparam int unsigned F7_5_BIT     = 30;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // addi x0,x0,0 so a freshly reset core decodes a harmless instruction
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: sequential pc+4 or PC-relative target, plus misalignment flag.
module fetch_unit_next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            pc_src,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misaligned_c
);

  // additions wrap modulo 2^XLEN
  assign pc_plus4_c   = pc + XLEN'(4);
  assign next_pc_c    = pc_src ? (pc + imm_ext) : pc_plus4_c;
  assign misaligned_c = |next_pc_c[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencing stage (REQ -> WAIT -> EXEC per instruction).
// Optional FETCH_ALIGN_CHECK_EN parks the stage on a misaligned next PC with a sticky fault.
module fetch_unit
#(
  parameter int unsigned       XLEN      = fetch_unit_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(fetch_unit_pkg::RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(fetch_unit_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            exec_stall,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7_5,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_fault
);

  import fetch_unit_pkg::*;

  fetch_state_e    state_q, state_n;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] instr_n;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  fetch_unit_next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc           (pc),
    .imm_ext      (imm_ext),
    .pc_src       (pc_src),
    .pc_plus4_c   (pc_plus4),
    .next_pc_c    (next_pc),
    .misaligned_c (misaligned)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_n;

  assign fetch_fault = fault_q;
  assign instr_valid = (state_q == EXEC) && !fault_q;
  assign imem_addr   = pc;
`else
  logic unused_misaligned;

  assign unused_misaligned = misaligned;
  assign fetch_fault       = 1'b0;
  assign instr_valid       = (state_q == EXEC);
  assign imem_addr         = {pc[XLEN-1:2], 2'b00};
`endif

  // request is suppressed while reset is held, whatever the state register holds
  assign imem_req_valid = (state_q == REQ) && !rst;

  assign opcode   = instr[OPC_LSB +: OPC_W];
  assign funct3   = instr[F3_LSB +: F3_W];
  assign funct7_5 = instr[F7_5_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      pc      <= pc_n;
      instr   <= instr_n;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc;
    instr_n = instr;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_n = fault_q;
`endif
    unique case (state_q)
      REQ: begin
        if (imem_req_ready) state_n = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_n = imem_rsp_data;
          state_n = EXEC;
        end
      end
      EXEC: begin
        // pc_src/imm_ext only matter on the cycle the stall drops
        if (!exec_stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (!fault_q) begin
            if (misaligned) begin
              fault_n = 1'b1;
            end else begin
              pc_n    = next_pc;
              state_n = REQ;
            end
          end
`else
          pc_n    = next_pc;
          state_n = REQ;
`endif
        end
      end
      default: state_n = REQ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven instruction sequence plus stall and reset corner cases.
module tb_fetch_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            pc_src;
  logic [XLEN-1:0] imm_ext;
  logic            exec_stall;
  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ready_dly;
    int          rsp_dly;
    logic [31:0] data;
    logic        src;
    logic [31:0] imm;
    logic [31:0] exp_pc;
    logic [6:0]  exp_opc;
    logic [2:0]  exp_f3;
    logic        exp_f75;
    logic [31:0] exp_next_pc;
  } vec_t;

  vec_t vecs [10];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_src         (pc_src),
    .imm_ext        (imm_ext),
    .exec_stall     (exec_stall),
    .instr          (instr),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7_5       (funct7_5),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    word_addr = a & 32'hFFFF_FFFC;
  endfunction

  // Starts at a negedge in REQ, ends at the negedge where EXEC is visible.
  task automatic fetch_to_exec(input vec_t v);
    chk("req_valid_req", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_addr, word_addr(v.exp_pc));
    chk("instr_valid_req", 32'(instr_valid), 32'd0);
    imem_req_ready = 1'b0;
    for (int k = 0; k < v.ready_dly; k++) begin
      @(negedge clk);
      chk("req_valid_hold", 32'(imem_req_valid), 32'd1);
      chk("req_addr_hold", imem_addr, word_addr(v.exp_pc));
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("req_valid_wait", 32'(imem_req_valid), 32'd0);
    chk("instr_valid_wait", 32'(instr_valid), 32'd0);
    for (int k = 0; k < v.rsp_dly; k++) begin
      @(negedge clk);
      chk("req_valid_wait_dly", 32'(imem_req_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = v.data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk("instr_valid_exec", 32'(instr_valid), 32'd1);
    chk("instr", instr, v.data);
    chk("opcode", 32'(opcode), 32'(v.exp_opc));
    chk("funct3", 32'(funct3), 32'(v.exp_f3));
    chk("funct7_5", 32'(funct7_5), 32'(v.exp_f75));
    chk("pc_exec", pc, v.exp_pc);
    chk("pc_plus4", pc_plus4, v.exp_pc + 32'd4);
    chk("req_valid_exec", 32'(imem_req_valid), 32'd0);
  endtask

  task automatic run_instr(input vec_t v);
    fetch_to_exec(v);
    pc_src     = v.src;
    imm_ext    = v.imm;
    exec_stall = 1'b0;
    @(negedge clk);
    pc_src  = 1'b0;
    imm_ext = 32'h0;
    chk("instr_valid_next", 32'(instr_valid), 32'd0);
    chk("req_valid_next", 32'(imem_req_valid), 32'd1);
    chk("pc_next", pc, v.exp_next_pc);
    chk("addr_next", imem_addr, word_addr(v.exp_next_pc));
  endtask

  initial begin
    vec_t st;

    //        rdy rsp data           src imm            pc             opc    f3    f75  next
    vecs[0] = '{0, 0, 32'h0050_0093, 1'b0, 32'h0000_0000, 32'h0000_0000, 7'h13, 3'd0, 1'b0, 32'h0000_0004};
    vecs[1] = '{5, 0, 32'h4020_8033, 1'b1, 32'h0000_000C, 32'h0000_0004, 7'h33, 3'd0, 1'b1, 32'h0000_0010};
    vecs[2] = '{0, 2, 32'h0020_9463, 1'b1, 32'hFFFF_FFF8, 32'h0000_0010, 7'h63, 3'd1, 1'b0, 32'h0000_0008};
    vecs[3] = '{1, 1, 32'h0000_A103, 1'b1, 32'h0000_0008, 32'h0000_0008, 7'h03, 3'd2, 1'b0, 32'h0000_0010};
    vecs[4] = '{0, 0, 32'h0020_9463, 1'b0, 32'hFFFF_FFF8, 32'h0000_0010, 7'h63, 3'd1, 1'b0, 32'h0000_0014};
    vecs[5] = '{0, 0, 32'h0080_006F, 1'b1, 32'h0000_002C, 32'h0000_0014, 7'h6F, 3'd0, 1'b0, 32'h0000_0040};
    // wrap-around and unchecked misaligned targets (low address bits masked)
    vecs[6] = '{0, 0, 32'h0000_0013, 1'b1, 32'hFFFF_FFA2, 32'h0000_0060, 7'h13, 3'd0, 1'b0, 32'h0000_0002};
    vecs[7] = '{0, 0, 32'h0010_0093, 1'b0, 32'h0000_0000, 32'h0000_0002, 7'h13, 3'd0, 1'b0, 32'h0000_0006};
    vecs[8] = '{2, 0, 32'h4000_5033, 1'b1, 32'h0000_0002, 32'h0000_0006, 7'h33, 3'd5, 1'b1, 32'h0000_0008};
    vecs[9] = '{0, 0, 32'h0050_0093, 1'b0, 32'h0000_0000, 32'h0000_0000, 7'h13, 3'd0, 1'b0, 32'h0000_0004};

    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    pc_src         = 1'b0;
    imm_ext        = 32'h0;
    exec_stall     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
    // stale response while in REQ must be ignored
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("stale_rsp_instr", instr, 32'h0000_0013);
    chk("stale_rsp_instr_valid", 32'(instr_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_instr(vecs[i]);

    // multi-cycle execute: only the cycle where the stall drops updates the PC
    st = '{0, 0, 32'h0020_A023, 1'b1, 32'h0000_0020, 32'h0000_0040, 7'h23, 3'd2, 1'b0, 32'h0000_0060};
    fetch_to_exec(st);
    exec_stall = 1'b1;
    imm_ext    = 32'h0000_0020;
    for (int k = 0; k < 3; k++) begin
      pc_src = k[0] ? 1'b1 : 1'b0;
      @(negedge clk);
      chk("stall_pc", pc, 32'h0000_0040);
      chk("stall_instr", instr, 32'h0020_A023);
      chk("stall_instr_valid", 32'(instr_valid), 32'd1);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    exec_stall = 1'b0;
    pc_src     = 1'b1;
    @(negedge clk);
    pc_src  = 1'b0;
    imm_ext = 32'h0;
    chk("stall_release_pc", pc, 32'h0000_0060);
    chk("stall_release_addr", imem_addr, 32'h0000_0060);
    chk("stall_release_req", 32'(imem_req_valid), 32'd1);

    for (int i = 6; i < 9; i++) run_instr(vecs[i]);

    // reset while waiting for a response, response lands in the following REQ cycle
    chk("rstw_addr_pre", imem_addr, 32'h0000_0008);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("rstw_in_wait", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("rstw_addr", imem_addr, 32'h0000_0000);
    chk("rstw_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rstw_instr", instr, 32'h0000_0013);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk("rstw_drop_instr", instr, 32'h0000_0013);
    chk("rstw_drop_valid", 32'(instr_valid), 32'd0);
    chk("rstw_still_req", 32'(imem_req_valid), 32'd1);
    chk("rstw_pc", pc, 32'h0000_0000);

    run_instr(vecs[9]);
    chk("final_fault", 32'(fetch_fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
